// File: rtl/pixel_block_splitter_if.sv
// Bundles the pixel stream, window/flush controls, packer job and read port of
// pixel_block_splitter. o_err exists only when PIXEL_BLOCK_SPLITTER_ERR_EN is defined.
interface pixel_block_splitter_if #(
    parameter int unsigned X_W    = 10,
    parameter int unsigned ADDR_W = 16
);
    logic              i_window_set;
    logic [X_W-1:0]    i_x_start;
    logic [X_W-1:0]    i_x_end;
    logic [X_W-1:0]    i_y_start;
    logic [X_W-1:0]    i_y_end;
    logic              i_pixel_valid;
    logic              o_pixel_ready;
    logic [15:0]       i_pixel_data;
    logic              i_flush;
    logic              o_pack_start;
    logic [4:0]        o_start_index;
    logic [4:0]        o_end_index;
    logic [ADDR_W-1:0] o_block_addr;
    logic              i_pack_done;
    logic              i_data_read;
    logic [15:0]       o_data;
    logic              o_busy;
`ifdef PIXEL_BLOCK_SPLITTER_ERR_EN
    logic              o_err;
`endif

    modport master (
        output i_window_set, i_x_start, i_x_end, i_y_start, i_y_end,
        output i_pixel_valid, i_pixel_data, i_flush, i_pack_done, i_data_read,
`ifdef PIXEL_BLOCK_SPLITTER_ERR_EN
        input  o_err,
`endif
        input  o_pixel_ready, o_pack_start, o_start_index, o_end_index, o_block_addr,
        input  o_data, o_busy
    );

    modport slave (
        input  i_window_set, i_x_start, i_x_end, i_y_start, i_y_end,
        input  i_pixel_valid, i_pixel_data, i_flush, i_pack_done, i_data_read,
`ifdef PIXEL_BLOCK_SPLITTER_ERR_EN
        output o_err,
`endif
        output o_pixel_ready, o_pack_start, o_start_index, o_end_index, o_block_addr,
        output o_data, o_busy
    );
endinterface

// File: rtl/pixel_block_splitter.sv
// Splits the decoded pixel stream into segments inside one 32-pixel block and row, queues
// one packer job per segment and serves pixels via a FIFO. Optional: PIXEL_BLOCK_SPLITTER_ERR_EN.
module pixel_block_splitter #(
    parameter int unsigned X_W         = 10,
    parameter int unsigned LINE_BLOCKS = 20,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned PIX_DEPTH   = 64,
    parameter int unsigned JOB_DEPTH   = 4
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    pixel_block_splitter_if.slave bus
);
    localparam int unsigned PW  = $clog2(PIX_DEPTH);
    localparam int unsigned PCW = PW + 1;
    localparam int unsigned JW  = (JOB_DEPTH > 1) ? $clog2(JOB_DEPTH) : 1;
    localparam int unsigned JCW = JW + 1;
    localparam int unsigned BW  = X_W - 5;

    typedef struct packed {
        logic [4:0]        s;
        logic [4:0]        e;
        logic [ADDR_W-1:0] addr;
    } job_t;

    typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

    logic [X_W-1:0] x_start_q, x_end_q, y_start_q, y_end_q, cx_q, cy_q;
    logic [X_W-1:0] x_start_d, x_end_d, y_start_d, y_end_d, cx_d, cy_d;
    logic           seg_open_q, seg_open_d;
    job_t           seg_q, seg_d, cur, job_a, job_b;
    logic [BW-1:0]  seg_blk_q, seg_blk_d, blk;
    logic [X_W-1:0] seg_row_q, seg_row_d;
    logic [ADDR_W-1:0] addr_calc;
    logic           accept, push_a, push_b, close;

    logic [15:0]    pix_mem [PIX_DEPTH];
    logic [PW-1:0]  pwr_q, prd_q;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic           pix_push, pix_pop, ready_q, ready_d;
    logic [15:0]    data_q;

    job_t           job_mem [JOB_DEPTH];
    logic [JW-1:0]  jwr_q, jrd_q, jwr_nx;
    logic [JCW-1:0] jcnt_q, jcnt_d;
    logic           job_pop, job_latch;

    state_e         state_q, state_d;
    job_t           out_q;

    assign accept    = bus.i_pixel_valid & ready_q;
    assign blk       = cx_q[X_W-1:5];
    assign addr_calc = ADDR_W'(cy_q) * ADDR_W'(LINE_BLOCKS) + ADDR_W'(blk);

    // Segment tracking: a pixel may close the previous segment (job_a) and its own (job_b).
    always_comb begin
        x_start_d  = x_start_q;
        x_end_d    = x_end_q;
        y_start_d  = y_start_q;
        y_end_d    = y_end_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        seg_open_d = seg_open_q;
        seg_d      = seg_q;
        seg_blk_d  = seg_blk_q;
        seg_row_d  = seg_row_q;
        push_a     = 1'b0;
        push_b     = 1'b0;
        job_a      = seg_q;
        job_b      = seg_q;
        cur        = seg_q;
        close      = 1'b0;
        if (accept) begin
            if (seg_open_q && (blk != seg_blk_q || cy_q != seg_row_q)) begin
                push_a = 1'b1;
            end
            if (!seg_open_q || push_a) begin
                cur.s    = cx_q[4:0];
                cur.addr = addr_calc;
            end
            cur.e = cx_q[4:0];
            if (cx_q == x_end_q) begin
                cx_d = x_start_q;
                cy_d = (cy_q == y_end_q) ? y_start_q : cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
            close     = (cx_q == x_end_q) || (&cx_q[4:0]) || bus.i_flush || bus.i_window_set;
            seg_d     = cur;
            seg_blk_d = blk;
            seg_row_d = cy_q;
            job_b     = cur;
            push_b    = close;
            seg_open_d = !close;
        end else if (seg_open_q && (bus.i_flush || bus.i_window_set)) begin
            push_b     = 1'b1;
            seg_open_d = 1'b0;
        end
        if (bus.i_window_set) begin
            x_start_d = bus.i_x_start;
            x_end_d   = bus.i_x_end;
            y_start_d = bus.i_y_start;
            y_end_d   = bus.i_y_end;
            cx_d      = bus.i_x_start;
            cy_d      = bus.i_y_start;
        end
    end

    assign pix_push = accept;
    assign pix_pop  = bus.i_data_read && (pcnt_q != '0);
    assign jwr_nx   = jwr_q + 1'b1;

    always_comb begin
        pcnt_d  = pcnt_q + PCW'(pix_push) - PCW'(pix_pop);
        jcnt_d  = jcnt_q + JCW'(push_a) + JCW'(push_b) - JCW'(job_pop);
        // Leaves room for one more pixel and two jobs closed by a single accept.
        ready_d = (pcnt_d <= PCW'(PIX_DEPTH - 2)) && (jcnt_d < JCW'(JOB_DEPTH - 1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_start_q  <= '0;
            x_end_q    <= '0;
            y_start_q  <= '0;
            y_end_q    <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            seg_open_q <= 1'b0;
            seg_q      <= '0;
            seg_blk_q  <= '0;
            seg_row_q  <= '0;
            pwr_q      <= '0;
            prd_q      <= '0;
            pcnt_q     <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            jwr_q      <= '0;
            jrd_q      <= '0;
            jcnt_q     <= '0;
            out_q      <= '0;
        end else begin
            x_start_q  <= x_start_d;
            x_end_q    <= x_end_d;
            y_start_q  <= y_start_d;
            y_end_q    <= y_end_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            seg_open_q <= seg_open_d;
            seg_q      <= seg_d;
            seg_blk_q  <= seg_blk_d;
            seg_row_q  <= seg_row_d;
            pwr_q      <= pwr_q + PW'(pix_push);
            prd_q      <= prd_q + PW'(pix_pop);
            pcnt_q     <= pcnt_d;
            ready_q    <= ready_d;
            jwr_q      <= jwr_q + JW'(push_a) + JW'(push_b);
            jrd_q      <= jrd_q + JW'(job_pop);
            jcnt_q     <= jcnt_d;
            if (pix_pop)   data_q <= pix_mem[prd_q];
            if (job_latch) out_q  <= job_mem[jrd_q];
        end
    end

    always_ff @(posedge i_clk) begin
        if (pix_push) pix_mem[pwr_q] <= bus.i_pixel_data;
        if (push_a)   job_mem[jwr_q] <= job_a;
        if (push_b)   job_mem[push_a ? jwr_nx : jwr_q] <= job_b;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (jcnt_q != '0) state_d = StStart;
            StStart: state_d = StWait;
            StWait:  if (bus.i_pack_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.o_pack_start = (state_q == StStart);
        job_latch        = (state_q == StIdle) && (jcnt_q != '0);
        job_pop          = (state_q == StWait) && bus.i_pack_done;
    end

    assign bus.o_pixel_ready = ready_q;
    assign bus.o_start_index = out_q.s;
    assign bus.o_end_index   = out_q.e;
    assign bus.o_block_addr  = out_q.addr;
    assign bus.o_data        = data_q;
    assign bus.o_busy        = (jcnt_q != '0) || seg_open_q;

`ifdef PIXEL_BLOCK_SPLITTER_ERR_EN
    logic err_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (err_q && !bus.i_window_set)
                   || (bus.i_data_read && pcnt_q == '0)
                   || (bus.i_pack_done && state_q != StWait)
                   || (accept && pcnt_q == PCW'(PIX_DEPTH));
        end
    end
    assign bus.o_err = err_q;
`endif
endmodule

// File: tb/tb_pixel_block_splitter.sv
// Bench for pixel_block_splitter: drives windows and pixel streams, predicts jobs and pixel
// order from window positions, and acts as packer/reader.
module tb_pixel_block_splitter;
    localparam int unsigned X_W = 10;
    localparam int unsigned ADDR_W = 16;
    localparam int LINE_BLOCKS = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pixel_block_splitter_if #(.X_W(X_W), .ADDR_W(ADDR_W)) bus ();

    pixel_block_splitter #(
        .X_W(X_W), .LINE_BLOCKS(LINE_BLOCKS), .ADDR_W(ADDR_W), .PIX_DEPTH(64), .JOB_DEPTH(4)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    typedef struct { int s; int e; int addr; } exp_job_t;

    exp_job_t    exp_jobs[$];
    logic [15:0] pix_q[$];
    bit          fl_q[$];
    bit          m_open;
    exp_job_t    m_cur;
    int checks = 0, errors = 0, start_cnt = 0, start_base = 0, accepted = 0;

    always @(posedge clk) if (bus.o_pack_start === 1'b1) start_cnt <= start_cnt + 1;

    // Expected jobs: pixel i lands at row-major position i of the window; a job spans
    // consecutive pixels until a row end, a block end or a flush.
    task automatic plan(input int xs, xe, ys, ye, n, fprob, input bit flush_last);
        int w, h, k, x, y;
        bit fl;
        logic [15:0] d;
        w = xe - xs + 1;
        h = ye - ys + 1;
        exp_jobs.delete(); pix_q.delete(); fl_q.delete();
        for (int i = 0; i < n; i++) begin
            k = i % (w * h);
            x = xs + k % w;
            y = ys + k / w;
            d = 16'($urandom) | 16'h0001;
            fl = (flush_last && i == n - 1) || ($urandom_range(99) < fprob);
            pix_q.push_back(d);
            fl_q.push_back(fl);
            if (!m_open) begin
                m_cur.s = x % 32;
                m_cur.addr = (y * LINE_BLOCKS + x / 32) % 65536;
                m_open = 1'b1;
            end
            m_cur.e = x % 32;
            if (fl || x == xe || x % 32 == 31) begin
                exp_jobs.push_back(m_cur);
                m_open = 1'b0;
            end
        end
    endtask

    task automatic set_window(input int xs, xe, ys, ye);
        @(negedge clk);
        bus.i_x_start = X_W'(xs);
        bus.i_x_end = X_W'(xe);
        bus.i_y_start = X_W'(ys);
        bus.i_y_end = X_W'(ye);
        bus.i_window_set = 1'b1;
        @(negedge clk);
        bus.i_window_set = 1'b0;
        m_open = 1'b0;
        start_base = start_cnt;
    endtask

    task automatic drive(input int gap_max);
        int n;
        for (int i = 0; i < pix_q.size(); i++) begin
            repeat ($urandom_range(gap_max)) @(negedge clk);
            bus.i_pixel_valid = 1'b1;
            bus.i_pixel_data = pix_q[i];
            n = 0;
            while (bus.o_pixel_ready !== 1'b1 && n < 5000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 5000) begin
                checks++; errors++;
                $display("FAIL ready_timeout: pixel %0d never accepted, ready=%b required 1",
                         i, bus.o_pixel_ready);
                bus.i_pixel_valid = 1'b0;
                return;
            end
            bus.i_flush = fl_q[i];
            @(negedge clk);
            accepted++;
            bus.i_pixel_valid = 1'b0;
            bus.i_flush = 1'b0;
        end
    endtask

    task automatic serve(input int hold_cycles, input int done_max);
        int n, pi, len;
        pi = 0;
        repeat (hold_cycles) @(negedge clk);
        for (int j = 0; j < exp_jobs.size(); j++) begin
            n = 0;
            while ((start_cnt - start_base) <= j && n < 5000) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n >= 5000) begin
                errors++;
                $display("FAIL job_timeout: job %0d pulses=%0d required %0d", j,
                         start_cnt - start_base, j + 1);
                return;
            end
            checks++;
            if (bus.o_start_index !== 5'(exp_jobs[j].s) || bus.o_end_index !== 5'(exp_jobs[j].e)
                || bus.o_block_addr !== 16'(exp_jobs[j].addr)) begin
                errors++;
                $display("FAIL job_fields: job %0d got (%0d,%0d,addr %0d) required (%0d,%0d,addr %0d)",
                         j, bus.o_start_index, bus.o_end_index, bus.o_block_addr,
                         exp_jobs[j].s, exp_jobs[j].e, exp_jobs[j].addr);
            end
            checks++;
            if (start_cnt - start_base != j + 1) begin
                errors++;
                $display("FAIL start_pulses: job %0d pulses=%0d required %0d", j,
                         start_cnt - start_base, j + 1);
            end
            len = exp_jobs[j].e - exp_jobs[j].s + 1;
            for (int k = 0; k < len; k++) begin
                bus.i_data_read = 1'b1;
                @(negedge clk);
                checks++;
                if (bus.o_data !== pix_q[pi]) begin
                    errors++;
                    $display("FAIL read_data: pixel %0d got %h required %h", pi, bus.o_data,
                             pix_q[pi]);
                end
                pi++;
            end
            bus.i_data_read = 1'b0;
            repeat ($urandom_range(done_max)) @(negedge clk);
            bus.i_pack_done = 1'b1;
            @(negedge clk);
            bus.i_pack_done = 1'b0;
        end
        repeat (8) @(negedge clk);
        checks++;
        if (start_cnt - start_base != exp_jobs.size()) begin
            errors++;
            $display("FAIL job_count: pulses=%0d required %0d", start_cnt - start_base,
                     exp_jobs.size());
        end
        checks++;
        if (bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: busy=%b required 0", bus.o_busy);
        end
    endtask

    task automatic test_reset();
        bus.i_window_set = 0; bus.i_x_start = 0; bus.i_x_end = 0; bus.i_y_start = 0;
        bus.i_y_end = 0; bus.i_pixel_valid = 0; bus.i_pixel_data = 0; bus.i_flush = 0;
        bus.i_pack_done = 0; bus.i_data_read = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.o_pixel_ready, bus.o_pack_start, bus.o_start_index, bus.o_end_index,
             bus.o_block_addr, bus.o_data, bus.o_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b start=%b s=%0d e=%0d addr=%0d data=%h busy=%b required all 0",
                     bus.o_pixel_ready, bus.o_pack_start, bus.o_start_index, bus.o_end_index,
                     bus.o_block_addr, bus.o_data, bus.o_busy);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.o_pixel_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_at_release: ready=%b required 0", bus.o_pixel_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.o_pixel_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_clock: ready=%b required 1", bus.o_pixel_ready);
        end
        // Reset window is the single pixel (0,0): every pixel is its own job.
        m_open = 1'b0;
        start_base = start_cnt;
        plan(0, 0, 0, 0, 2, 0, 1'b0);
        fork
            drive(0);
            serve(0, 0);
        join
    endtask

    task automatic test_window(input int xs, xe, ys, ye, n);
        set_window(xs, xe, ys, ye);
        plan(xs, xe, ys, ye, n, 0, 1'b0);
        fork
            drive(1);
            serve(0, 2);
        join
    endtask

    task automatic test_flush();
        set_window(0, 639, 0, 0);
        plan(0, 639, 0, 0, 3, 0, 1'b0);
        drive(0);
        @(negedge clk);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        if (m_open) begin
            exp_jobs.push_back(m_cur);
            m_open = 1'b0;
        end
        serve(0, 1);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (start_cnt - start_base != 1 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_flush: pulses=%0d busy=%b required 1 and 0",
                     start_cnt - start_base, bus.o_busy);
        end
    endtask

    task automatic test_backpressure();
        set_window(0, 639, 0, 0);
        plan(0, 639, 0, 0, 640, 0, 1'b0);
        accepted = 0;
        fork
            drive(0);
            serve(200, 0);
            begin
                repeat (150) @(negedge clk);
                checks++;
                if (accepted != 63 || bus.o_pixel_ready !== 1'b0 || bus.o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_state: accepted=%0d ready=%b busy=%b required 63, 0, 1",
                             accepted, bus.o_pixel_ready, bus.o_busy);
                end
                checks++;
                if (start_cnt - start_base != 1) begin
                    errors++;
                    $display("FAIL stall_jobs: pulses=%0d required 1", start_cnt - start_base);
                end
            end
        join
    endtask

    task automatic test_reset_mid_wait();
        int n;
        set_window(3, 639, 0, 0);
        plan(3, 639, 0, 0, 2, 0, 1'b1);
        drive(0);
        n = 0;
        while (start_cnt - start_base < 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.i_data_read = 1'b1;
        @(negedge clk);
        bus.i_data_read = 1'b0;
        checks++;
        if (bus.o_data !== pix_q[0] || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: data=%h busy=%b required %h and 1", bus.o_data,
                     bus.o_busy, pix_q[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_pixel_ready, bus.o_pack_start, bus.o_start_index, bus.o_end_index,
             bus.o_block_addr, bus.o_data, bus.o_busy} !== '0) begin
            errors++;
            $display("FAIL mid_wait_reset: ready=%b start=%b s=%0d e=%0d addr=%0d data=%h busy=%b required all 0",
                     bus.o_pixel_ready, bus.o_pack_start, bus.o_start_index, bus.o_end_index,
                     bus.o_block_addr, bus.o_data, bus.o_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_window(7, 639, 0, 0);
        plan(7, 639, 0, 0, 1, 0, 1'b1);
        fork
            drive(0);
            serve(0, 0);
        join
    endtask

    task automatic test_random();
        int xs, xe, ys, ye;
        for (int it = 0; it < 6; it++) begin
            xs = $urandom_range(600);
            xe = xs + $urandom_range(39);
            if (xe > 639) xe = 639;
            ys = $urandom_range(10);
            ye = ys + $urandom_range(2);
            set_window(xs, xe, ys, ye);
            plan(xs, xe, ys, ye, $urandom_range(90, 1), 8, 1'b1);
            fork
                drive(2);
                serve($urandom_range(20), 3);
            join
        end
    endtask

    initial begin
        test_reset();
        test_window(0, 639, 0, 0, 64);
        test_window(5, 9, 3, 4, 10);
        test_window(30, 33, 0, 0, 4);
        test_flush();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
